bus_mem_responder: RTL and testbench



---
 rtl/bus_mem_responder_pkg.sv | 12 +
 rtl/bus_mem_responder_if.sv | 24 ++
 rtl/bus_mem_array.sv | 31 +++
 rtl/bus_mem_responder.sv | 131 +++++++++++++
 tb/tb_bus_mem_responder.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/bus_mem_responder_pkg.sv
// Shared CPU memory-bus definitions: default word width and responder FSM encodings.
package bus_mem_responder_pkg;

  localparam int WORD_SIZE_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/bus_mem_responder_if.sv
// CPU memory-bus request/completion signals; the bidirectional data bus is a plain inout on the top.
interface bus_mem_responder_if
  import bus_mem_responder_pkg::*;
#(
  parameter int WORD_SIZE = WORD_SIZE_DEFAULT
) ();

  logic                 readM;
  logic                 writeM;
  logic [WORD_SIZE-1:0] address;
  logic                 mem_ready;
  logic                 bus_err;

  modport master (
    output readM, writeM, address,
    input  mem_ready, bus_err
  );

  modport slave (
    input  readM, writeM, address,
    output mem_ready, bus_err
  );

endinterface

// File: rtl/bus_mem_array.sv
// Word array with combinational read, a bus write port and a preload port; the bus write wins on a shared index.
module bus_mem_array #(
  parameter int WORD_SIZE  = 16,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  bus_we,
  input  logic [ADDR_WIDTH-1:0] bus_addr,
  input  logic [WORD_SIZE-1:0]  bus_wdata,
  input  logic                  init_we,
  input  logic [ADDR_WIDTH-1:0] init_addr,
  input  logic [WORD_SIZE-1:0]  init_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [WORD_SIZE-1:0]  rd_data
);

  logic [WORD_SIZE-1:0] mem [0:(1<<ADDR_WIDTH)-1];

  // Preload and bus write land together unless they target the same word.
  always_ff @(posedge clk) begin
    if (init_we && !(bus_we && (bus_addr == init_addr))) begin
      mem[init_addr] <= init_data;
    end
    if (bus_we) begin
      mem[bus_addr] <= bus_wdata;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/bus_mem_responder.sv
// Memory-side responder for the CPU bus: fixed-latency loads/stores with a mem_ready strobe and access counters.
module bus_mem_responder
  import bus_mem_responder_pkg::*;
#(
  parameter int WORD_SIZE  = WORD_SIZE_DEFAULT,
  parameter int ADDR_WIDTH = 8,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  bus_mem_responder_if.slave    bus,
  inout  wire  [WORD_SIZE-1:0]  data,
  input  logic                  init_we,
  input  logic [ADDR_WIDTH-1:0] init_addr,
  input  logic [WORD_SIZE-1:0]  init_data,
  output logic [15:0]           rd_count,
  output logic [15:0]           wr_count
);

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  bus_err_q, bus_err_d;
  logic [15:0]           rd_count_q, rd_count_d;
  logic [15:0]           wr_count_q, wr_count_d;
  logic                  op_wr_q, op_wr_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [WORD_SIZE-1:0]  wdata_q, wdata_d;

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [WORD_SIZE-1:0]  mem_wdata;
  logic [WORD_SIZE-1:0]  rd_data;
  logic                  data_oe;
  logic                  unused_addr_hi;

  assign unused_addr_hi = ^bus.address[WORD_SIZE-1:ADDR_WIDTH];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bus_err_d  = 1'b0;
    rd_count_d = rd_count_q;
    wr_count_d = wr_count_q;
    op_wr_d    = op_wr_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    mem_we     = 1'b0;
    mem_waddr  = idx_q;
    mem_wdata  = wdata_q;
    case (state_q)
      IDLE: begin
        if (bus.readM && bus.writeM) begin
          bus_err_d = 1'b1;
        end else if (bus.readM || bus.writeM) begin
          op_wr_d = bus.writeM;
          idx_d   = bus.address[ADDR_WIDTH-1:0];
          if (bus.writeM) wdata_d = data;
          cnt_d = 4'(LATENCY);
          if (LATENCY == 0) begin
            // Zero latency commits straight from the bus at the accepting edge.
            state_d   = RESP;
            mem_we    = bus.writeM;
            mem_waddr = bus.address[ADDR_WIDTH-1:0];
            mem_wdata = data;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = RESP;
          mem_we  = op_wr_q;
        end
      end
      RESP: begin
        state_d = IDLE;
        if (op_wr_q) wr_count_d = wr_count_q + 16'd1;
        else         rd_count_d = rd_count_q + 16'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      bus_err_q  <= 1'b0;
      rd_count_q <= 16'd0;
      wr_count_q <= 16'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bus_err_q  <= bus_err_d;
      rd_count_q <= rd_count_d;
      wr_count_q <= wr_count_d;
    end
  end

  always_ff @(posedge clk) begin
    op_wr_q <= op_wr_d;
    idx_q   <= idx_d;
    wdata_q <= wdata_d;
  end

  // A reset on the commit edge abandons the store.
  bus_mem_array #(
    .WORD_SIZE (WORD_SIZE),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_array (
    .clk      (clk),
    .bus_we   (mem_we && reset_n),
    .bus_addr (mem_waddr),
    .bus_wdata(mem_wdata),
    .init_we  (init_we),
    .init_addr(init_addr),
    .init_data(init_data),
    .rd_addr  (idx_q),
    .rd_data  (rd_data)
  );

  assign data_oe       = (state_q == RESP) && !op_wr_q;
  assign data          = data_oe ? rd_data : {WORD_SIZE{1'bz}};
  assign bus.mem_ready = (state_q == RESP);
  assign bus.bus_err   = bus_err_q;
  assign rd_count      = rd_count_q;
  assign wr_count      = wr_count_q;

endmodule

// File: tb/tb_bus_mem_responder.sv
// Directed bench for bus_mem_responder: a LATENCY=2 instance and a LATENCY=0 instance side by side.
module tb_bus_mem_responder;
  import bus_mem_responder_pkg::*;

  logic clk;
  logic rst_a_n, rst_b_n;
  logic init_we;
  logic [7:0] init_addr;
  logic [15:0] init_data;

  bus_mem_responder_if #(.WORD_SIZE(16)) ifa ();
  bus_mem_responder_if #(.WORD_SIZE(16)) ifb ();

  wire  [15:0] data_a, data_b;
  logic [15:0] cpu_dout_a;
  logic        cpu_oe_a;
  logic [15:0] rd_count_a, wr_count_a, rd_count_b, wr_count_b;

  assign data_a = cpu_oe_a ? cpu_dout_a : 16'hzzzz;
  assign data_b = 16'hzzzz;

  bus_mem_responder #(.WORD_SIZE(16), .ADDR_WIDTH(8), .LATENCY(2)) dut_a (
    .clk(clk), .reset_n(rst_a_n), .bus(ifa), .data(data_a),
    .init_we(init_we), .init_addr(init_addr), .init_data(init_data),
    .rd_count(rd_count_a), .wr_count(wr_count_a)
  );

  bus_mem_responder #(.WORD_SIZE(16), .ADDR_WIDTH(8), .LATENCY(0)) dut_b (
    .clk(clk), .reset_n(rst_b_n), .bus(ifb), .data(data_b),
    .init_we(init_we), .init_addr(init_addr), .init_data(init_data),
    .rd_count(rd_count_b), .wr_count(wr_count_b)
  );

  int errors = 0;
  int checks = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One access on instance A, request asserted until mem_ready is seen.
  task automatic acc_a(input bit wr, input logic [15:0] addr, input logic [15:0] wdata,
                       output int lat, output logic [15:0] rdata, output bit oe, output int bad_oe);
    ifa.readM   = !wr;
    ifa.writeM  = wr;
    ifa.address = addr;
    cpu_dout_a  = wdata;
    cpu_oe_a    = wr;
    lat = -1; rdata = 16'h0; oe = 1'b0; bad_oe = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (ifa.mem_ready) begin
        lat   = k;
        rdata = data_a;
        oe    = dut_a.data_oe;
        break;
      end else if (dut_a.data_oe) begin
        bad_oe++;
      end
    end
    ifa.readM  = 1'b0;
    ifa.writeM = 1'b0;
    cpu_oe_a   = 1'b0;
    tick();
    if (dut_a.data_oe) bad_oe++;
  endtask

  int          lat, bad, seen;
  logic [15:0] rd;
  bit          oe;

  initial begin
    rst_a_n = 1'b0; rst_b_n = 1'b0;
    init_we = 1'b0; init_addr = 8'h0; init_data = 16'h0;
    ifa.readM = 1'b0; ifa.writeM = 1'b0; ifa.address = 16'h0;
    ifb.readM = 1'b0; ifb.writeM = 1'b0; ifb.address = 16'h0;
    cpu_dout_a = 16'h0; cpu_oe_a = 1'b0;
    tick(); tick();

    // Preload while both instances are held in reset.
    init_we = 1'b1; init_addr = 8'h05; init_data = 16'h1234; tick();
    init_addr = 8'h03; init_data = 16'h00AA; tick();
    init_addr = 8'h20; init_data = 16'h5555; tick();
    init_we = 1'b0;
    rst_a_n = 1'b1; rst_b_n = 1'b1;

    chk("rst_state", 32'(dut_a.state_q), 32'(IDLE));
    chk("rst_ready", 32'(ifa.mem_ready), 32'd0);
    chk("rst_buserr", 32'(ifa.bus_err), 32'd0);
    chk("rst_oe", 32'(dut_a.data_oe), 32'd0);
    chk("rst_rdcnt", 32'(rd_count_a), 32'd0);
    chk("rst_wrcnt", 32'(wr_count_a), 32'd0);

    acc_a(1'b0, 16'h0005, 16'h0, lat, rd, oe, bad);
    chk("rd5_lat", 32'(lat), 32'd2);
    chk("rd5_data", 32'(rd), 32'h1234);
    chk("rd5_oe", 32'(oe), 32'd1);
    chk("rd5_z_else", 32'(bad), 32'd0);
    chk("rd5_rdcnt", 32'(rd_count_a), 32'd1);

    acc_a(1'b1, 16'h0010, 16'hBEEF, lat, rd, oe, bad);
    chk("wr10_lat", 32'(lat), 32'd2);
    chk("wr10_oe_resp", 32'(oe), 32'd0);
    chk("wr10_z_else", 32'(bad), 32'd0);
    chk("wr10_wrcnt", 32'(wr_count_a), 32'd1);
    acc_a(1'b0, 16'h0010, 16'h0, lat, rd, oe, bad);
    chk("rd10_data", 32'(rd), 32'hBEEF);
    chk("rd10_rdcnt", 32'(rd_count_a), 32'd2);

    // Conflicting request.
    ifa.readM = 1'b1; ifa.writeM = 1'b1; ifa.address = 16'h0010;
    cpu_dout_a = 16'hDEAD; cpu_oe_a = 1'b1;
    tick();
    chk("err_pulse", 32'(ifa.bus_err), 32'd1);
    chk("err_noready", 32'(ifa.mem_ready), 32'd0);
    ifa.readM = 1'b0; ifa.writeM = 1'b0; cpu_oe_a = 1'b0;
    tick();
    chk("err_end", 32'(ifa.bus_err), 32'd0);
    chk("err_state", 32'(dut_a.state_q), 32'(IDLE));
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (ifa.mem_ready) seen++;
    end
    chk("err_noready_later", 32'(seen), 32'd0);
    chk("err_rdcnt", 32'(rd_count_a), 32'd2);
    chk("err_wrcnt", 32'(wr_count_a), 32'd1);
    acc_a(1'b0, 16'h0010, 16'h0, lat, rd, oe, bad);
    chk("err_mem_kept", 32'(rd), 32'hBEEF);

    // Reset during WAIT of a write.
    ifa.writeM = 1'b1; ifa.address = 16'h0020; cpu_dout_a = 16'h7777; cpu_oe_a = 1'b1;
    tick();
    chk("rstw_in_wait", 32'(dut_a.state_q), 32'(WAIT));
    rst_a_n = 1'b0;
    tick();
    rst_a_n = 1'b1;
    ifa.writeM = 1'b0; cpu_oe_a = 1'b0;
    chk("rstw_state", 32'(dut_a.state_q), 32'(IDLE));
    chk("rstw_ready", 32'(ifa.mem_ready), 32'd0);
    chk("rstw_rdcnt", 32'(rd_count_a), 32'd0);
    chk("rstw_wrcnt", 32'(wr_count_a), 32'd0);
    seen = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (ifa.mem_ready) seen++;
    end
    chk("rstw_noready", 32'(seen), 32'd0);
    acc_a(1'b0, 16'h0020, 16'h0, lat, rd, oe, bad);
    chk("rstw_old_val", 32'(rd), 32'h5555);
    chk("rstw_rdcnt2", 32'(rd_count_a), 32'd1);

    // Preload and bus commit to index 0x30 on the same edge.
    ifa.writeM = 1'b1; ifa.address = 16'h0030; cpu_dout_a = 16'h2222; cpu_oe_a = 1'b1;
    tick();
    tick();
    init_we = 1'b1; init_addr = 8'h30; init_data = 16'h1111;
    tick();
    init_we = 1'b0;
    chk("same_edge_ready", 32'(ifa.mem_ready), 32'd1);
    ifa.writeM = 1'b0; cpu_oe_a = 1'b0;
    tick();
    acc_a(1'b0, 16'h0030, 16'h0, lat, rd, oe, bad);
    chk("same_edge_win", 32'(rd), 32'h2222);
    acc_a(1'b0, 16'h0130, 16'h0, lat, rd, oe, bad);
    chk("alias_130", 32'(rd), 32'h2222);

    // Zero-latency instance with readM held continuously.
    ifb.readM = 1'b1; ifb.address = 16'h0003;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk($sformatf("l0_ready_%0d", k), 32'(ifb.mem_ready), 32'((k % 2) == 0));
      if ((k % 2) == 0) chk($sformatf("l0_data_%0d", k), 32'(data_b), 32'h00AA);
    end
    ifb.readM = 1'b0;
    chk("l0_rdcnt", 32'(rd_count_b), 32'd4);
    chk("l0_wrcnt", 32'(wr_count_b), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
